// File: rtl/efpga_accel_responder.sv
// eFPGA-side responder for the CPU coprocessor operand/operator/strobe/done handshake.
// Define EFPGA_ACCEL_MUL_EN to build the 32-cycle shift-add multiplier for operator 10.
module efpga_accel_responder #(
  parameter int DW      = 32,
  parameter int DELAY_W = 4
) (
  input  logic               clk_i,
  input  logic               reset,
  input  logic               en_i,
  input  logic               write_strobe_i,
  input  logic [DW-1:0]      operand_a_i,
  input  logic [DW-1:0]      operand_b_i,
  input  logic [1:0]         operator_i,
  input  logic [DELAY_W-1:0] delay_i,
  output logic [DW-1:0]      result_a_o,
  output logic [DW-1:0]      result_b_o,
  output logic [DW-1:0]      result_c_o,
  output logic               fpga_done_o,
  output logic               busy_o
);

  // state | meaning
  // IDLE  | waiting for a strobe
  // EXEC  | computing (1 cycle, or one multiplier bit per cycle)
  // WAIT  | counting down the extra completion delay
  // DONE  | results valid, done held high
  typedef enum logic [1:0] {IDLE, EXEC, WAIT, DONE} state_t;

  state_t             state;
  logic [DW-1:0]      op_a;
  logic [DW-1:0]      op_b;
  logic [1:0]         opcode;
  logic [DELAY_W-1:0] cnt;
  logic [DW:0]        sum;
  logic [DW:0]        diff;
  logic               ult;
  logic               slt;
  logic               accept;
  logic               exec_last;
  logic [DW-1:0]      calc_a;
  logic [DW-1:0]      calc_b;
  logic [DW-1:0]      calc_c;

  assign accept = en_i && write_strobe_i && (state == IDLE || state == DONE);
  assign sum    = {1'b0, op_a} + {1'b0, op_b};
  assign diff   = {1'b0, op_a} - {1'b0, op_b};
  assign ult    = op_a < op_b;
  assign slt    = $signed(op_a) < $signed(op_b);

`ifdef EFPGA_ACCEL_MUL_EN
  localparam int BW = $clog2(DW);
  localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);

  logic [2*DW-1:0] mcand;
  logic [2*DW-1:0] prod;
  logic [2*DW-1:0] prod_next;
  logic [DW-1:0]   mplier;
  logic [BW-1:0]   bit_cnt;

  assign prod_next = prod + (mplier[0] ? mcand : '0);
  assign exec_last = (opcode != 2'b10) || (bit_cnt == LAST_BIT);

  // The datapath steps freely in EXEC; only the FSM decides whether the result lands.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      prod    <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      mcand   <= {{DW{1'b0}}, operand_a_i};
      mplier  <= operand_b_i;
      prod    <= '0;
      bit_cnt <= '0;
    end else if (state == EXEC) begin
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      prod    <= prod_next;
      bit_cnt <= bit_cnt + BW'(1);
    end
  end
`else
  assign exec_last = 1'b1;
`endif

  always_comb begin
    calc_a = '0;
    calc_b = '0;
    calc_c = '0;
    case (opcode)
      2'b00: begin
        calc_a = sum[DW-1:0];
        calc_b = diff[DW-1:0];
        calc_c = {{(DW-2){1'b0}}, diff[DW], sum[DW]};
      end
      2'b01: begin
        calc_a = op_a & op_b;
        calc_b = op_a | op_b;
        calc_c = op_a ^ op_b;
      end
      2'b10: begin
`ifdef EFPGA_ACCEL_MUL_EN
        calc_a = prod_next[DW-1:0];
        calc_b = prod_next[2*DW-1:DW];
        calc_c = DW'(DW);
`else
        calc_c = '1;
`endif
      end
      default: begin
        calc_a = ult ? op_a : op_b;
        calc_b = ult ? op_b : op_a;
        calc_c = {{(DW-3){1'b0}}, op_a == op_b, slt, ult};
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      opcode      <= '0;
      cnt         <= '0;
      result_a_o  <= '0;
      result_b_o  <= '0;
      result_c_o  <= '0;
      fpga_done_o <= 1'b0;
      busy_o      <= 1'b0;
    end else if (!en_i) begin
      state       <= IDLE;
      fpga_done_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (write_strobe_i) begin
            op_a        <= operand_a_i;
            op_b        <= operand_b_i;
            opcode      <= operator_i;
            cnt         <= delay_i;
            state       <= EXEC;
            busy_o      <= 1'b1;
            fpga_done_o <= 1'b0;
          end
        end
        EXEC: begin
          if (exec_last) begin
            result_a_o <= calc_a;
            result_b_o <= calc_b;
            result_c_o <= calc_c;
            if (cnt == '0) begin
              state       <= DONE;
              busy_o      <= 1'b0;
              fpga_done_o <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - DELAY_W'(1);
          if (cnt <= DELAY_W'(1)) begin
            state       <= DONE;
            busy_o      <= 1'b0;
            fpga_done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_efpga_accel_responder.sv
// Self-checking bench for efpga_accel_responder: directed scenarios plus randomized ops
// compared against a behavioural model; follows EFPGA_ACCEL_MUL_EN like the design.
module tb_efpga_accel_responder;

`ifdef EFPGA_ACCEL_MUL_EN
  localparam bit MUL = 1'b1;
`else
  localparam bit MUL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        strobe;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic [3:0]  dly;
  logic [31:0] res_a;
  logic [31:0] res_b;
  logic [31:0] res_c;
  logic        done;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_a, last_b, last_c;

  efpga_accel_responder dut (
    .clk_i          (clk),
    .reset          (reset),
    .en_i           (en),
    .write_strobe_i (strobe),
    .operand_a_i    (a),
    .operand_b_i    (b),
    .operator_i     (op),
    .delay_i        (dly),
    .result_a_o     (res_a),
    .result_b_o     (res_b),
    .result_c_o     (res_c),
    .fpga_done_o    (done),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic [1:0] o,
                                output logic [31:0] ea, output logic [31:0] eb, output logic [31:0] ec);
    logic [63:0] wide;
    case (o)
      2'd0: begin
        wide = {32'b0, x} + {32'b0, y};
        ea = x + y;
        eb = x - y;
        ec = {30'b0, x < y, wide[32]};
      end
      2'd1: begin
        ea = x & y;
        eb = x | y;
        ec = x ^ y;
      end
      2'd2: begin
        if (MUL) begin
          wide = {32'b0, x} * {32'b0, y};
          ea = wide[31:0];
          eb = wide[63:32];
          ec = 32'd32;
        end else begin
          ea = 32'h0;
          eb = 32'h0;
          ec = 32'hFFFF_FFFF;
        end
      end
      default: begin
        ea = (x < y) ? x : y;
        eb = (x < y) ? y : x;
        ec = {29'b0, x == y, $signed(x) < $signed(y), x < y};
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [3:0] d);
    return ((o == 2'd2 && MUL) ? 33 : 2) + int'(d);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  // Pulses the strobe in cycle N and returns the cycle offset at which done is first seen.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [1:0] o,
                        input logic [3:0] d, output int lat, output bit busy_ok);
    @(posedge clk); #1;
    a = x; b = y; op = o; dly = d; strobe = 1'b1;
    @(posedge clk); #1;
    strobe = 1'b0;
    lat = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; strobe = 1'b0; a = '0; b = '0; op = '0; dly = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({res_a, res_b, res_c, done, busy} !== 98'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got a=%h b=%h c=%h done=%b busy=%b, want all 0", res_a, res_b, res_c, done, busy);
    end
    reset = 1'b0; en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: got done=%b busy=%b, want 0 0", done, busy);
    end
    last_a = '0; last_b = '0; last_c = '0;
  endtask

  task automatic test_addsub();
    int lat; bit bok;
    run_op(32'hFFFF_FFFF, 32'h1, 2'd0, 4'd0, lat, bok);
    n_checks++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL addsub_latency: got %0d, want 2", lat);
    end
    n_checks++;
    if ({res_a, res_b, res_c} !== {32'h0, 32'hFFFF_FFFE, 32'h1}) begin
      n_fail++;
      $display("FAIL addsub_results: got %h %h %h, want 00000000 fffffffe 00000001", res_a, res_b, res_c);
    end
    last_a = 32'h0; last_b = 32'hFFFF_FFFE; last_c = 32'h1;
  endtask

  task automatic test_compare_delay();
    int lat; bit bok;
    run_op(32'h8000_0000, 32'h5, 2'd3, 4'd3, lat, bok);
    n_checks++;
    if (lat !== 5) begin
      n_fail++;
      $display("FAIL compare_latency: got %0d, want 5", lat);
    end
    n_checks++;
    if (bok !== 1'b1) begin
      n_fail++;
      $display("FAIL compare_busy: busy dropped before done, got %b want 1", bok);
    end
    n_checks++;
    if ({res_a, res_b, res_c} !== {32'h5, 32'h8000_0000, 32'h2}) begin
      n_fail++;
      $display("FAIL compare_results: got %h %h %h, want 00000005 80000000 00000002", res_a, res_b, res_c);
    end
    last_a = 32'h5; last_b = 32'h8000_0000; last_c = 32'h2;
  endtask

  task automatic test_done_hold();
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if ({done, busy, res_a, res_b, res_c} !== {2'b10, last_a, last_b, last_c}) begin
      n_fail++;
      $display("FAIL done_hold: got done=%b busy=%b %h %h %h, want 1 0 %h %h %h",
               done, busy, res_a, res_b, res_c, last_a, last_b, last_c);
    end
  endtask

  task automatic test_multiply();
    int lat; bit bok;
    logic [31:0] ea, eb, ec;
    model(32'hFFFF_FFFF, 32'h2, 2'd2, ea, eb, ec);
    run_op(32'hFFFF_FFFF, 32'h2, 2'd2, 4'd0, lat, bok);
    n_checks++;
    if (lat !== exp_lat(2'd2, 4'd0)) begin
      n_fail++;
      $display("FAIL mul_latency: got %0d, want %0d", lat, exp_lat(2'd2, 4'd0));
    end
    n_checks++;
    if ({res_a, res_b, res_c} !== {ea, eb, ec}) begin
      n_fail++;
      $display("FAIL mul_results: got %h %h %h, want %h %h %h", res_a, res_b, res_c, ea, eb, ec);
    end
    last_a = ea; last_b = eb; last_c = ec;
  endtask

  task automatic test_strobe_while_busy();
    int lat;
    logic [31:0] ea, eb, ec;
    model(32'h1234_5678, 32'h9ABC_DEF0, 2'd2, ea, eb, ec);
    @(posedge clk); #1;
    a = 32'h1234_5678; b = 32'h9ABC_DEF0; op = 2'd2; dly = 4'd15; strobe = 1'b1;
    @(posedge clk); #1;
    strobe = 1'b0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (k == 10) begin
        a = 32'h1; b = 32'h1; op = 2'd0; dly = 4'd0; strobe = 1'b1;
      end else begin
        strobe = 1'b0;
      end
      @(posedge clk); #1;
    end
    strobe = 1'b0;
    n_checks++;
    if (lat !== exp_lat(2'd2, 4'd15)) begin
      n_fail++;
      $display("FAIL busy_strobe_latency: got %0d, want %0d", lat, exp_lat(2'd2, 4'd15));
    end
    n_checks++;
    if ({res_a, res_b, res_c} !== {ea, eb, ec}) begin
      n_fail++;
      $display("FAIL busy_strobe_results: got %h %h %h, want %h %h %h", res_a, res_b, res_c, ea, eb, ec);
    end
    last_a = ea; last_b = eb; last_c = ec;
  endtask

  task automatic test_back_to_back();
    int lat; bit bok;
    run_op(32'h6, 32'h3, 2'd1, 4'd0, lat, bok);
    n_checks++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL b2b_latency: got %0d, want 2", lat);
    end
    n_checks++;
    if ({res_a, res_b, res_c} !== {32'h2, 32'h7, 32'h5}) begin
      n_fail++;
      $display("FAIL b2b_results: got %h %h %h, want 00000002 00000007 00000005", res_a, res_b, res_c);
    end
    last_a = 32'h2; last_b = 32'h7; last_c = 32'h5;
  endtask

  task automatic test_en_low();
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL en_low_clear: got done=%b busy=%b, want 0 0", done, busy);
    end
    a = 32'h55; b = 32'h22; op = 2'd0; dly = 4'd0; strobe = 1'b1;
    @(posedge clk); #1;
    strobe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({done, busy, res_a, res_b, res_c} !== {2'b00, last_a, last_b, last_c}) begin
      n_fail++;
      $display("FAIL en_low_strobe: got done=%b busy=%b %h %h %h, want 0 0 %h %h %h",
               done, busy, res_a, res_b, res_c, last_a, last_b, last_c);
    end
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL en_restore_idle: got done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_abort_en();
    logic [31:0] ea, eb, ec;
    model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2, ea, eb, ec);
    // A multiply has not registered anything by N+5; a single-cycle op already has.
    if (MUL) begin
      ea = last_a; eb = last_b; ec = last_c;
    end
    @(posedge clk); #1;
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; op = 2'd2; dly = 4'd15; strobe = 1'b1;
    @(posedge clk); #1;
    strobe = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_busy_before: got %b, want 1", busy);
    end
    en = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({done, busy, res_a, res_b, res_c} !== {2'b00, ea, eb, ec}) begin
      n_fail++;
      $display("FAIL abort_en: got done=%b busy=%b %h %h %h, want 0 0 %h %h %h",
               done, busy, res_a, res_b, res_c, ea, eb, ec);
    end
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_stays_idle: got done=%b busy=%b, want 0 0", done, busy);
    end
    last_a = ea; last_b = eb; last_c = ec;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    a = 32'hDEAD_BEEF; b = 32'h0000_1234; op = 2'd2; dly = 4'd15; strobe = 1'b1;
    @(posedge clk); #1;
    strobe = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({res_a, res_b, res_c, done, busy} !== 98'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got a=%h b=%h c=%h done=%b busy=%b, want all 0", res_a, res_b, res_c, done, busy);
    end
    reset = 1'b0;
    last_a = '0; last_b = '0; last_c = '0;
  endtask

  task automatic test_random();
    int lat; bit bok;
    logic [31:0] x, y, ea, eb, ec;
    logic [1:0] o;
    logic [3:0] d;
    for (int i = 0; i < 40; i++) begin
      x = pick();
      y = ($urandom_range(0, 7) == 0) ? x : pick();
      o = 2'($urandom_range(0, 3));
      d = 4'($urandom_range(0, 15));
      model(x, y, o, ea, eb, ec);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      run_op(x, y, o, d, lat, bok);
      n_checks++;
      if (lat !== exp_lat(o, d)) begin
        n_fail++;
        $display("FAIL rand_latency[%0d] op=%0d d=%0d: got %0d, want %0d", i, o, d, lat, exp_lat(o, d));
      end
      n_checks++;
      if ({res_a, res_b, res_c} !== {ea, eb, ec}) begin
        n_fail++;
        $display("FAIL rand_results[%0d] op=%0d a=%h b=%h: got %h %h %h, want %h %h %h",
                 i, o, x, y, res_a, res_b, res_c, ea, eb, ec);
      end
      n_checks++;
      if ({bok, busy} !== 2'b10) begin
        n_fail++;
        $display("FAIL rand_busy[%0d]: got busy_held=%b busy_at_done=%b, want 1 0", i, bok, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_compare_delay();
    test_done_hold();
    test_multiply();
    test_strobe_while_busy();
    test_back_to_back();
    test_en_low();
    test_abort_en();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
